fetch_line_buffer: RTL
======================

FETCH_LINE_BUFFER -- requirements
Module: fetch_line_buffer

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 8, meaning 32-bit words per buffered line (power of two, 2..16).
REQ-002 SHALL have parameter ADDR_W, default 40, meaning instruction address width.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 clean  in  1  flush: invalidate line, abandon pending miss.
REQ-007 fetch_valid  in  1  fetch request, lane 0 (taskValid[0]).
REQ-008 fetch_address  in  ADDR_W  byte address of requested instruction.
REQ-009 fetch_ready  out  1  fetch_rdata/fetch_error valid this cycle (taskReady[0]).
REQ-010 fetch_rdata  out  32  instruction word (readBus[0]).
REQ-011 fetch_error  out  1  access error (taskError[0]).
REQ-012 mem_req  out  1  line read request, held until granted.
REQ-013 mem_addr  out  ADDR_W  line-aligned base address.
REQ-014 mem_gnt  in  1  request accepted this cycle.
REQ-015 mem_rvalid  in  1  one read beat, ascending word order.
REQ-016 mem_rdata  in  32  beat data.
REQ-017 mem_rerr  in  1  beat error, qualified by mem_rvalid.

Function
REQ-018 Hit = line_valid && fetch_address[ADDR_W-1:log2(LINE_WORDS)+2] == tag && fetch_address[1:0]==0; on fetch_valid && hit, fetch_ready=1 combinationally same cycle, fetch_rdata=word[fetch_address index], fetch_error=0.
REQ-019 fetch_valid with fetch_address[1:0]!=0: fetch_ready=1, fetch_error=1, fetch_rdata=0, same cycle, no memory access.
REQ-020 States: IDLE, REQ, FILL, DRAIN.
REQ-021 IDLE: fetch_valid && aligned && miss && no matching err_pending -> REQ next cycle; tag captured, line_valid cleared.
REQ-022 REQ: mem_req=1, mem_addr=captured line base; mem_gnt -> FILL, beat counter=0.
REQ-023 FILL: each mem_rvalid writes word[counter], ORs mem_rerr into fill_err, counter+1; beat LINE_WORDS-1 -> IDLE.
REQ-024 Fill end, fill_err=0: line_valid=1; requested word hits per REQ-018 from the following cycle (miss latency = grant cycle + LINE_WORDS beats + 1).
REQ-025 Fill end, fill_err=1: line_valid=0, err_pending=1, err_addr=line base.
REQ-026 err_pending && fetch_valid && address in err_addr line: fetch_ready=1, fetch_error=1, fetch_rdata=0; err_pending cleared next edge.
REQ-027 fetch_ready=0 in every other case, including REQ/FILL/DRAIN regardless of fetch_address changes.
REQ-028 clean in IDLE: line_valid, err_pending cleared next edge.
REQ-029 clean in REQ: mem_req dropped next cycle, -> IDLE; clean coincident with mem_gnt -> DRAIN (grant counts).
REQ-030 clean in FILL -> DRAIN, counter kept; DRAIN consumes remaining beats, discards data, -> IDLE on last beat with line_valid=0, err_pending=0.
REQ-031 fetch_ready SHALL be forced 0 in any cycle clean=1.
REQ-032 Counter width log2(LINE_WORDS); wraps to 0 after last beat; beats outside FILL/DRAIN ignored.

Reset
REQ-033 rst asynchronously forces state=IDLE, line_valid=0, err_pending=0, fill_err=0, counter=0, mem_req=0, mem_addr=0, fetch_ready=0, fetch_error=0, fetch_rdata=0; line data not reset.
REQ-034 Reset during FILL abandons the fill; memory side is reset by the same rst.

Structure
REQ-035 Shared package SHALL hold FetchLineBuf_State_t enum and default LINE_WORDS constant.
REQ-036 Line storage SHALL be sub-module fetch_line_store (LINE_WORDS x 32 registers, one write port, one combinational read port).

Verification
REQ-037 Cold miss: fetch 0x00_0000_1008, gnt after 2 cycles, 8 clean beats 0x1000+i -> mem_addr=0x00_0000_1000, fetch_ready one cycle after last beat, rdata=0x1002.
REQ-038 Hit: after REQ-037, fetch 0x00_0000_101C -> fetch_ready same cycle, rdata=0x1007, mem_req stays 0.
REQ-039 Error fill: beat 3 has mem_rerr=1 -> fetch_ready=1, fetch_error=1 once; refetch of same address issues new mem_req.
REQ-040 Misaligned: fetch 0x00_0000_2002 -> fetch_ready=1, fetch_error=1 same cycle, no mem_req.
REQ-041 clean at beat 4 of 8 -> DRAIN takes beats 5..7 without fetch_ready, then IDLE, refetch misses.
REQ-042 rst asserted mid-FILL -> all outputs 0 immediately, next fetch misses.

Source files
------------

// File: rtl/fetch_line_buffer_pkg.sv
// Shared types and defaults for the single-line instruction fetch buffer.
package fetch_line_buffer_pkg;

  localparam int DEFAULT_LINE_WORDS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FILL  = 2'd2,
    DRAIN = 2'd3
  } FetchLineBuf_State_t;

endpackage

// File: rtl/fetch_line_store.sv
// Line data storage: LINE_WORDS x 32-bit registers, one write port, one
// combinational read port. Contents are deliberately not reset.
module fetch_line_store #(
  parameter int LINE_WORDS = 8,
  parameter int IDX_W      = $clog2(LINE_WORDS)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [31:0]      wdata_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [LINE_WORDS];

  // Capture one beat per write strobe.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_line_buffer.sv
// Single-line instruction fetch buffer: answers hits and misaligned fetches
// in the request cycle, refills the line from memory on a miss, and reports
// a failed refill once as an access error.
//
// state | meaning
// IDLE  | serve hits / misaligned / pending error, launch a miss
// REQ   | mem_req held for the captured line until granted
// FILL  | take LINE_WORDS beats into the line store
// DRAIN | flushed mid-refill: swallow remaining beats, keep line invalid
module fetch_line_buffer
  import fetch_line_buffer_pkg::*;
#(
  parameter int LINE_WORDS = DEFAULT_LINE_WORDS,
  parameter int ADDR_W     = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clean,
  input  logic              fetch_valid,
  input  logic [ADDR_W-1:0] fetch_address,
  output logic              fetch_ready,
  output logic [31:0]       fetch_rdata,
  output logic              fetch_error,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_rerr
);

  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam int OFF_W = IDX_W + 2;
  localparam int TAG_W = ADDR_W - OFF_W;

  FetchLineBuf_State_t state_q;
  logic             line_valid_q;
  logic             err_pending_q;
  logic             fill_err_q;
  logic             mem_req_q;
  logic [TAG_W-1:0] tag_q;
  logic [TAG_W-1:0] err_tag_q;
  logic [IDX_W-1:0] cnt_q;

  logic [TAG_W-1:0] fa_tag;
  logic [IDX_W-1:0] fa_idx;
  logic             aligned;
  logic             req_ok;
  logic             misalign_rsp;
  logic             hit_rsp;
  logic             err_rsp;
  logic             miss_start;
  logic             last_beat;
  logic             store_we;
  logic [31:0]      rd_word;

  assign fa_tag  = fetch_address[ADDR_W-1:OFF_W];
  assign fa_idx  = fetch_address[OFF_W-1:2];
  assign aligned = (fetch_address[1:0] == 2'b00);

  // Responses only come from IDLE; flush and reset silence them outright.
  assign req_ok       = fetch_valid && (state_q == IDLE) && !clean && !rst;
  assign misalign_rsp = req_ok && !aligned;
  assign hit_rsp      = req_ok && aligned && line_valid_q && (fa_tag == tag_q);
  assign err_rsp      = req_ok && aligned && err_pending_q && (fa_tag == err_tag_q);
  assign miss_start   = req_ok && aligned && !hit_rsp && !err_rsp;

  assign fetch_ready = misalign_rsp || hit_rsp || err_rsp;
  assign fetch_error = misalign_rsp || err_rsp;
  assign fetch_rdata = hit_rsp ? rd_word : 32'h0;

  assign mem_req  = mem_req_q;
  assign mem_addr = {tag_q, {OFF_W{1'b0}}};

  assign last_beat = (cnt_q == IDX_W'(LINE_WORDS - 1));
  assign store_we  = (state_q == FILL) && mem_rvalid && !clean;

  fetch_line_store #(
    .LINE_WORDS (LINE_WORDS),
    .IDX_W      (IDX_W)
  ) u_store (
    .clk_i   (clk),
    .we_i    (store_we),
    .waddr_i (cnt_q),
    .wdata_i (mem_rdata),
    .raddr_i (fa_idx),
    .rdata_o (rd_word)
  );

  // Refill sequencer: miss launch, grant handshake, beat counting, flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      line_valid_q  <= 1'b0;
      err_pending_q <= 1'b0;
      fill_err_q    <= 1'b0;
      mem_req_q     <= 1'b0;
      tag_q         <= '0;
      err_tag_q     <= '0;
      cnt_q         <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clean) begin
            line_valid_q  <= 1'b0;
            err_pending_q <= 1'b0;
          end else if (err_rsp) begin
            err_pending_q <= 1'b0;
          end else if (miss_start) begin
            tag_q        <= fa_tag;
            line_valid_q <= 1'b0;
            mem_req_q    <= 1'b1;
            state_q      <= REQ;
          end
        end
        REQ: begin
          // A grant in the flush cycle still commits memory to a full line.
          if (mem_gnt) begin
            mem_req_q  <= 1'b0;
            cnt_q      <= '0;
            fill_err_q <= 1'b0;
            state_q    <= clean ? DRAIN : FILL;
          end else if (clean) begin
            mem_req_q     <= 1'b0;
            err_pending_q <= 1'b0;
            state_q       <= IDLE;
          end
        end
        FILL: begin
          if (mem_rvalid) begin
            cnt_q      <= cnt_q + IDX_W'(1);
            fill_err_q <= fill_err_q | mem_rerr;
            if (last_beat) begin
              state_q <= IDLE;
              if (clean) begin
                line_valid_q  <= 1'b0;
                err_pending_q <= 1'b0;
              end else if (fill_err_q || mem_rerr) begin
                line_valid_q  <= 1'b0;
                err_pending_q <= 1'b1;
                err_tag_q     <= tag_q;
              end else begin
                line_valid_q <= 1'b1;
              end
            end else if (clean) begin
              state_q <= DRAIN;
            end
          end else if (clean) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (mem_rvalid) begin
            cnt_q <= cnt_q + IDX_W'(1);
            if (last_beat) begin
              state_q       <= IDLE;
              line_valid_q  <= 1'b0;
              err_pending_q <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
